gcd_req_ctrl: RTL and testbench
===============================

Name: gcd_req_ctrl

Overview:
- Requester-side controller for the subtractive GCD core, which has a start/x/y in and gcd/done out interface with a synchronous rst.
- Accepts operand pairs on a valid/ready input stream and short-circuits zero operands, since the core never terminates for x=0, y≠0.
- Issues non-trivial pairs to the core, waits for done, and presents the result on a valid/ready output stream.
- Bounds core run time with a watchdog and recovers a hung or slow core through core_rst.

Parameters:
- W, 32, operand and result width.
- TIMEOUT, 4096, maximum WAIT cycles before abort. Must be ≥2.
- CW, 16, width of the res_cycles counter. 2^CW−1 must be ≥ TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept a pair.
- in_x  in  W  operand x.
- in_y  in  W  operand y.
- core_start  out  1  start pulse to the core.
- core_x  out  W  operand x to the core.
- core_y  out  W  operand y to the core.
- core_rst  out  1  synchronous reset to the core, one-cycle pulse.
- core_gcd  in  W  core result.
- core_done  in  1  core done level.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_gcd  out  W  GCD result.
- res_err  out  1  result is a timeout abort.
- res_cycles  out  CW  WAIT cycles spent; 0 for short-circuited pairs.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0 except core_rst=1, which is held while rst is high and for the first cycle after release so the core starts clean.
- in_ready = (state==IDLE) && !res_valid. This is combinational from registers only.
- States: IDLE, ISSUE, SETTLE, WAIT, RESP, ABORT.
- IDLE: on in_valid&&in_ready, register the operands.
  - If in_x==0 or in_y==0: go to RESP with res_gcd = in_x|in_y, res_err=0, res_cycles=0. The core is not started.
  - Otherwise: go to ISSUE, with core_x/core_y loaded.
- ISSUE: core_start=1 for exactly this one cycle; core_x/core_y stay stable from ISSUE until leaving WAIT. Go to SETTLE.
- SETTLE: one cycle during which the core clears done. core_done is ignored. Clear the cycle counter. Go to WAIT.
- WAIT: counter increments each cycle.
  - If core_done==1: capture core_gcd into res_gcd, res_err=0, res_cycles=counter value, then go to RESP.
  - Else if counter == TIMEOUT−1: go to ABORT.
  - core_done takes priority over timeout when both occur in the same cycle.
- ABORT: core_rst=1 for one cycle; res_gcd=0, res_err=1, res_cycles=TIMEOUT. Go to RESP.
- RESP: res_valid=1; res_gcd, res_err and res_cycles are held stable while res_valid && !res_ready. On res_ready, clear res_valid and go to IDLE.
  - in_ready stays 0 in the res_ready cycle, so the earliest new accept is the following cycle.
- Latency, non-trivial pair: accept edge T → ISSUE in cycle T+1 → SETTLE at T+2 → WAIT from T+3. res_valid rises on the edge after core_done is seen.
- Short-circuit latency: res_valid rises on the accept edge.
- The counter saturates and never wraps.
- A core_done glitch during IDLE, RESP or ABORT is ignored.
- core_start is never asserted outside ISSUE.
- rst asserted mid-operation: immediate return to IDLE, res_valid=0, any pending result is discarded, and core_rst is asserted.

Test Plan:
- Pair (48,18) → core_start pulses once; after core_done, res_gcd=6, res_err=0, res_cycles = WAIT count observed (≥4); in_ready=0 throughout.
- Pairs (0,35), (7,0) and (0,0) → res_gcd = 35, 7 and 0 respectively, res_cycles=0, and core_start never asserted.
- (48,18) with res_ready held low 10 cycles → res_valid and res_gcd=6 stable for all 10 cycles, in_ready=0; res_ready=1 → in_ready returns 1 one cycle later.
- TIMEOUT=16 with pair (1000,1) → after 16 WAIT cycles, one core_rst pulse, then res_err=1, res_gcd=0, res_cycles=16; the next pair (21,14) then yields 7.
- Back-to-back pairs (12,8) then (17,5) with res_ready=1 → results 4 then 1 in order; no second core_start before the first result is consumed.
- rst pulsed during WAIT of (1000,1) → all outputs reset, core_rst high; after release, pair (9,6) → 3.

Source files
------------

// File: rtl/gcd_req_ctrl.sv
// Requester-side controller for a subtractive GCD core: accepts operand pairs,
// short-circuits zero operands, runs the core under a watchdog, returns results.
module gcd_req_ctrl #(
  parameter int W       = 32,
  parameter int TIMEOUT = 4096,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_y,
  output logic          core_start,
  output logic [W-1:0]  core_x,
  output logic [W-1:0]  core_y,
  output logic          core_rst,
  input  logic [W-1:0]  core_gcd,
  input  logic          core_done,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_gcd,
  output logic          res_err,
  output logic [CW-1:0] res_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_RESP, S_ABORT
  } state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  x_reg, x_next;
  logic [W-1:0]  y_reg, y_next;
  logic [W-1:0]  gcd_reg, gcd_next;
  logic          err_reg, err_next;
  logic [CW-1:0] cycles_reg, cycles_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] cnt_inc;
  logic          rst_hold_reg;

  // Saturating increment: the WAIT counter never wraps.
  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      gcd_reg      <= '0;
      err_reg      <= 1'b0;
      cycles_reg   <= '0;
      cnt_reg      <= '0;
      rst_hold_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      gcd_reg      <= gcd_next;
      err_reg      <= err_next;
      cycles_reg   <= cycles_next;
      cnt_reg      <= cnt_next;
      rst_hold_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    gcd_next    = gcd_reg;
    err_next    = err_reg;
    cycles_next = cycles_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          // The core never terminates with a zero operand, so answer directly.
          if (in_x == '0 || in_y == '0) begin
            gcd_next    = in_x | in_y;
            err_next    = 1'b0;
            cycles_next = '0;
            state_next  = S_RESP;
          end else begin
            x_next     = in_x;
            y_next     = in_y;
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE:  state_next = S_SETTLE;
      S_SETTLE: begin
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        cnt_next = cnt_inc;
        if (core_done) begin
          gcd_next    = core_gcd;
          err_next    = 1'b0;
          cycles_next = cnt_inc;
          state_next  = S_RESP;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          state_next = S_ABORT;
        end
      end
      S_ABORT: begin
        gcd_next    = '0;
        err_next    = 1'b1;
        cycles_next = CW'(TIMEOUT);
        state_next  = S_RESP;
      end
      S_RESP: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign res_valid  = (state_reg == S_RESP);
  assign in_ready   = (state_reg == S_IDLE) && !res_valid;
  assign core_start = (state_reg == S_ISSUE);
  assign core_rst   = rst_hold_reg || (state_reg == S_ABORT);
  assign core_x     = x_reg;
  assign core_y     = y_reg;
  assign res_gcd    = gcd_reg;
  assign res_err    = err_reg;
  assign res_cycles = cycles_reg;

endmodule

// File: tb/tb_gcd_req_ctrl.sv
// Directed bench for gcd_req_ctrl with a behavioural subtractive GCD core.
module tb_gcd_req_ctrl;
  localparam int W = 32;
  localparam int TIMEOUT = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic core_start;
  logic [W-1:0] core_x, core_y;
  logic core_rst;
  logic [W-1:0] core_gcd;
  logic core_done;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [W-1:0] res_gcd;
  logic res_err;
  logic [CW-1:0] res_cycles;

  always #5 clk = ~clk;

  gcd_req_ctrl #(.W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .core_start(core_start), .core_x(core_x), .core_y(core_y), .core_rst(core_rst),
    .core_gcd(core_gcd), .core_done(core_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_gcd(res_gcd), .res_err(res_err), .res_cycles(res_cycles)
  );

  // Behavioural core: one subtraction per cycle, done level when x==y.
  logic [W-1:0] cx = '0, cy = '0;
  logic cdone = 1'b0;
  always @(posedge clk) begin
    if (core_rst) begin
      cx <= '0; cy <= '0; cdone <= 1'b0;
    end else if (core_start) begin
      cx <= core_x; cy <= core_y; cdone <= 1'b0;
    end else if (!cdone) begin
      if (cx > cy) cx <= cx - cy;
      else if (cy > cx) cy <= cy - cx;
      else cdone <= 1'b1;
    end
  end
  assign core_gcd = cx;
  assign core_done = cdone;

  int start_count = 0;
  int crst_count = 0;
  logic [W-1:0] got_q[$];
  int snap_q[$];
  always @(posedge clk) begin
    if (core_start) start_count <= start_count + 1;
    if (core_rst) crst_count <= crst_count + 1;
    if (res_valid && res_ready) begin
      got_q.push_back(res_gcd);
      snap_q.push_back(start_count);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin tick(); n++; end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_x = x; in_y = y;
    tick();
    in_valid = 1'b0;
    $display("send %s x=%0d y=%0d", tag, x, y);
  endtask

  task automatic wait_result(input string tag, output int lat, output logic ir_seen);
    lat = 0;
    ir_seen = 1'b0;
    while (!res_valid && lat < 200) begin
      ir_seen |= in_ready;
      tick();
      lat++;
    end
    check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    $display("result %s gcd=%0d err=%0d cycles=%0d lat=%0d", tag, res_gcd, res_err, res_cycles, lat);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    logic ir_seen;
    int s0, c0;
    logic stable_ok;
    logic [W-1:0] sx[3];
    logic [W-1:0] sy[3];
    logic [W-1:0] sg[3];
    sx = '{32'd0, 32'd7, 32'd0};
    sy = '{32'd35, 32'd0, 32'd0};
    sg = '{32'd35, 32'd7, 32'd0};

    // Reset
    repeat (3) tick();
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_res_gcd", 64'(res_gcd), 64'd0);
    rst = 1'b0;
    check("rel_core_rst_hold", 64'(core_rst), 64'd1);
    tick();
    check("rel_core_rst_low", 64'(core_rst), 64'd0);
    check("rel_in_ready", 64'(in_ready), 64'd1);
    tick();

    // (48,18) with res_ready held low for 10 cycles
    s0 = start_count;
    send("p48_18", 32'd48, 32'd18);
    wait_result("p48_18", lat, ir_seen);
    check("p48_18_gcd", 64'(res_gcd), 64'd6);
    check("p48_18_err", 64'(res_err), 64'd0);
    check("p48_18_cycles", 64'(res_cycles), 64'(lat - 2));
    check("p48_18_cycles_ge4", 64'(res_cycles >= 4), 64'd1);
    check("p48_18_in_ready_low", 64'(ir_seen), 64'd0);
    check("p48_18_starts", 64'(start_count - s0), 64'd1);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(res_valid === 1'b1 && res_gcd === 32'd6 && in_ready === 1'b0 && res_cycles === CW'(lat - 2)))
        stable_ok = 1'b0;
      tick();
    end
    check("hold_stable", 64'(stable_ok), 64'd1);
    res_ready = 1'b1;
    #1;
    check("hold_rdy_cycle_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("hold_after_res_valid", 64'(res_valid), 64'd0);
    check("hold_after_in_ready", 64'(in_ready), 64'd1);

    // Zero-operand short circuits
    for (int i = 0; i < 3; i++) begin
      s0 = start_count;
      send("zero", sx[i], sy[i]);
      check("zero_res_valid_on_accept", 64'(res_valid), 64'd1);
      check("zero_gcd", 64'(res_gcd), 64'(sg[i]));
      check("zero_cycles", 64'(res_cycles), 64'd0);
      check("zero_err", 64'(res_err), 64'd0);
      consume();
      check("zero_no_start", 64'(start_count - s0), 64'd0);
    end

    // Watchdog abort on (1000,1)
    c0 = crst_count;
    send("p1000_1", 32'd1000, 32'd1);
    wait_result("p1000_1", lat, ir_seen);
    check("to_err", 64'(res_err), 64'd1);
    check("to_gcd", 64'(res_gcd), 64'd0);
    check("to_cycles", 64'(res_cycles), 64'(TIMEOUT));
    check("to_latency", 64'(lat), 64'(TIMEOUT + 3));
    check("to_core_rst_pulses", 64'(crst_count - c0), 64'd1);
    consume();
    send("p21_14", 32'd21, 32'd14);
    wait_result("p21_14", lat, ir_seen);
    check("p21_14_gcd", 64'(res_gcd), 64'd7);
    check("p21_14_err", 64'(res_err), 64'd0);
    consume();

    // Back-to-back with res_ready held high
    got_q.delete();
    snap_q.delete();
    s0 = start_count;
    res_ready = 1'b1;
    send("p12_8", 32'd12, 32'd8);
    send("p17_5", 32'd17, 32'd5);
    lat = 0;
    while (got_q.size() < 2 && lat < 200) begin tick(); lat++; end
    res_ready = 1'b0;
    check("b2b_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      $display("b2b results %0d %0d", got_q[0], got_q[1]);
      check("b2b_first", 64'(got_q[0]), 64'd4);
      check("b2b_second", 64'(got_q[1]), 64'd1);
      check("b2b_starts_at_first", 64'(snap_q[0] - s0), 64'd1);
    end

    // Reset in the middle of WAIT
    tick();
    send("p1000_1_rst", 32'd1000, 32'd1);
    repeat (6) tick();
    check("mid_no_result", 64'(res_valid), 64'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_core_rst", 64'(core_rst), 64'd1);
    check("mid_rst_core_x", 64'(core_x), 64'd0);
    check("mid_rst_core_start", 64'(core_start), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("mid_rel_core_rst", 64'(core_rst), 64'd0);
    send("p9_6", 32'd9, 32'd6);
    wait_result("p9_6", lat, ir_seen);
    check("p9_6_gcd", 64'(res_gcd), 64'd3);
    check("p9_6_err", 64'(res_err), 64'd0);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
